// File: rtl/weight_adder.sv
// Per-class weight memory: CLASSN rows of CLAUSEN packed 9-bit weights, one weight read per cycle.
// Latency: 1 cycle from clause_no/clauses/row change to weight; no backpressure, weight updates every edge.
module weight_adder #(
  parameter int CLAUSEN = 10,
  parameter int CLASSN  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wea2,
  input  logic [$clog2(CLASSN)-1:0]  bram_addr_a2,
  input  logic [$clog2(CLASSN)-1:0]  bram_addr_2,
  input  logic [9*CLAUSEN-1:0]       weight_write,
  input  logic [8:0]                 clauses,
  input  logic [$clog2(CLAUSEN):0]   clause_no,
  output logic [8:0]                 weight
);

  localparam int ROW_W = 9 * CLAUSEN;

  // Rows start at zero and are deliberately left out of the reset domain.
  logic [ROW_W-1:0] mem_q [CLASSN] = '{default: '0};

  logic             wr_ok;
  int               rd_idx;
  logic             rd_ok;
  logic [ROW_W-1:0] rd_row;
  logic [8:0]       weight_d;
  logic [8:0]       weight_q;

  assign wr_ok = rst && wea2 && (int'(bram_addr_a2) < CLASSN);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[bram_addr_a2] <= weight_write;
    end
  end

  // Clause 1 sits in the most-significant used slot, so the slot index counts down from clauses.
  always_comb begin
    rd_idx   = int'(clauses) - int'(clause_no);
    rd_ok    = (clause_no != '0) && (int'(clause_no) <= int'(clauses)) &&
               (rd_idx < CLAUSEN) && (int'(bram_addr_2) < CLASSN);
    rd_row   = '0;
    weight_d = '0;
    for (int r = 0; r < CLASSN; r++) begin
      if (int'(bram_addr_2) == r) rd_row = mem_q[r];
    end
    if (rd_ok) begin
      for (int s = 0; s < CLAUSEN; s++) begin
        if (rd_idx == s) weight_d = rd_row[s*9 +: 9];
      end
    end
  end

  // Sampling mem_q on the same edge as a write gives read-first behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_q <= '0;
    end else begin
      weight_q <= weight_d;
    end
  end

  assign weight = weight_q;

endmodule

// File: tb/tb_weight_adder.sv
// Directed bench for weight_adder: slice mapping, invalid reads, read-first writes and async reset.
module tb_weight_adder;

  localparam int CLAUSEN = 10;
  localparam int CLASSN  = 10;

  logic         clk;
  logic         rst;
  logic         wea2;
  logic [3:0]   bram_addr_a2;
  logic [3:0]   bram_addr_2;
  logic [89:0]  weight_write;
  logic [8:0]   clauses;
  logic [4:0]   clause_no;
  logic [8:0]   weight;

  int n_tests = 0;
  int n_fail  = 0;

  logic [89:0] row_a;
  logic [89:0] row_b;
  logic [89:0] row_c;
  logic [89:0] row_s;

  weight_adder #(.CLAUSEN(CLAUSEN), .CLASSN(CLASSN)) dut (
    .clk          (clk),
    .rst          (rst),
    .wea2         (wea2),
    .bram_addr_a2 (bram_addr_a2),
    .bram_addr_2  (bram_addr_2),
    .weight_write (weight_write),
    .clauses      (clauses),
    .clause_no    (clause_no),
    .weight       (weight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 9'h%03h expected 9'h%03h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    wea2         = 1'b0;
    bram_addr_a2 = 4'd0;
    bram_addr_2  = 4'd3;
    weight_write = '0;
    clauses      = 9'd10;
    clause_no    = 5'd1;

    #1 chk("reset_state", weight, 9'h000);
    tick();
    tick();
    chk("reset_hold", weight, 9'h000);

    rst = 1'b1;
    tick();
    chk("powerup_zero", weight, 9'h000);

    // Row 3: slot9=005, slot3=07A, slot0=1FF
    row_a = '0;
    row_a[9*9 +: 9] = 9'h005;
    row_a[3*9 +: 9] = 9'h07A;
    row_a[0*9 +: 9] = 9'h1FF;
    weight_write = row_a;
    bram_addr_a2 = 4'd3;
    wea2 = 1'b1;
    tick();
    wea2 = 1'b0;

    clause_no = 5'd1;  tick(); chk("c10_n1", weight, 9'h005);
    clause_no = 5'd10; tick(); chk("c10_n10", weight, 9'h1FF);

    clauses = 9'd4;
    clause_no = 5'd1;  tick(); chk("c4_n1", weight, 9'h07A);
    clause_no = 5'd5;  tick(); chk("c4_n5_over", weight, 9'h000);
    clause_no = 5'd0;  tick(); chk("c4_n0", weight, 9'h000);
    clause_no = 5'd4;  tick(); chk("c4_n4", weight, 9'h1FF);

    clauses = 9'd12;
    clause_no = 5'd1;  tick(); chk("c12_k11", weight, 9'h000);
    clause_no = 5'd3;  tick(); chk("c12_k9", weight, 9'h005);

    // Row 2 write, then an out-of-range write; row 3 must be untouched
    row_b = '0;
    row_b[0*9 +: 9] = 9'h0C3;
    row_b[9*9 +: 9] = 9'h0C3;
    weight_write = row_b;
    bram_addr_a2 = 4'd2;
    wea2 = 1'b1;
    tick();
    bram_addr_a2 = 4'd12;
    tick();
    wea2 = 1'b0;

    clauses = 9'd10;
    clause_no = 5'd10; tick(); chk("row3_kept_s0", weight, 9'h1FF);
    clause_no = 5'd1;  tick(); chk("row3_kept_s9", weight, 9'h005);

    bram_addr_2 = 4'd2;
    clause_no = 5'd10; tick(); chk("row2_read", weight, 9'h0C3);
    bram_addr_2 = 4'd11;
    tick(); chk("bad_row", weight, 9'h000);
    bram_addr_2 = 4'd3;

    // Read-during-write on row 3 slot0: 1FF -> 010
    row_c = row_a;
    row_c[0*9 +: 9] = 9'h010;
    weight_write = row_c;
    bram_addr_a2 = 4'd3;
    clause_no = 5'd10;
    wea2 = 1'b1;
    tick(); chk("rdw_old", weight, 9'h1FF);
    wea2 = 1'b0;
    tick(); chk("rdw_new", weight, 9'h010);

    // Asynchronous reset mid-cycle; a write attempted during reset must be dropped
    #2 rst = 1'b0;
    #1 chk("async_reset", weight, 9'h000);
    weight_write = row_a;
    wea2 = 1'b1;
    tick(); chk("reset_hold_wr", weight, 9'h000);
    wea2 = 1'b0;
    rst = 1'b1;
    clause_no = 5'd10;
    tick(); chk("reset_retain", weight, 9'h010);

    // Sweep: slot i holds i+1, so clause_no c reads slot 10-c = 11-c
    for (int i = 0; i < CLAUSEN; i++) row_s[i*9 +: 9] = 9'(i + 1);
    weight_write = row_s;
    bram_addr_a2 = 4'd3;
    wea2 = 1'b1;
    tick();
    wea2 = 1'b0;
    for (int c = 1; c <= CLAUSEN; c++) begin
      clause_no = 5'(c);
      tick();
      chk($sformatf("sweep_n%0d", c), weight, 9'(11 - c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/weight_adder.md
WEIGHT_ADDER -- requirements
Module: weight_adder

Interface
REQ-001 Parameter CLAUSEN, default 10, maximum number of clauses per class (weights per memory row).
REQ-002 Parameter CLASSN, default 10, number of classes (memory rows).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all sequential logic.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 wea2  input  1  weight-row write enable, active-high, sampled on clk rising edge.
REQ-007 bram_addr_a2  input  $clog2(CLASSN)  write row (class) address.
REQ-008 bram_addr_2  input  $clog2(CLASSN)  read row (class) address; static per instance, tied to its class index.
REQ-009 weight_write  input  9*CLAUSEN  full row write data; CLAUSEN packed 9-bit two's-complement weights.
REQ-010 clauses  input  9  number of active clauses (1..CLAUSEN).
REQ-011 clause_no  input  $clog2(CLAUSEN)+1  1-based clause index to read.
REQ-012 weight  output  9  registered two's-complement weight of clause clause_no in row bram_addr_2.

Function
REQ-013 Storage: array of CLASSN rows x 9*CLAUSEN bits; every row SHALL power up at all zeros; contents SHALL NOT be cleared by rst.
REQ-014 Write: on clk rising edge with wea2=1 and bram_addr_a2<CLASSN, row[bram_addr_a2] SHALL take weight_write in full.
REQ-015 Write with bram_addr_a2>=CLASSN SHALL be ignored, with no row modified.
REQ-016 Slice mapping: clause j (1-based) of a row SHALL occupy bits [(clauses-j)*9 +: 9]; clause 1 is the most-significant used slot.
REQ-017 Read index k = clauses - clause_no, computed at least 10 bits wide without wrap.
REQ-018 Read valid when 1<=clause_no<=clauses and k<CLAUSEN and bram_addr_2<CLASSN.
REQ-019 When read valid, weight SHALL register row[bram_addr_2][k*9 +: 9] on each clk rising edge.
REQ-020 When read invalid (clause_no=0, clause_no>clauses, clauses>CLAUSEN giving k>=CLAUSEN, or bad row), weight SHALL register 9'h000.
REQ-021 Read latency exactly 1 cycle from clause_no, clauses or row change to weight.
REQ-022 weight SHALL update every cycle, with no enable; a change in clause_no is reflected on the next edge.
REQ-023 Read-during-write to the same row SHALL be read-first: weight shows the pre-write slice that cycle and the new data from the next edge.
REQ-024 Weight values are passed unmodified; sign interpretation (e.g. 9'h1FF = -1) belongs to the consumer; no arithmetic is performed on them.

Reset
REQ-025 rst=0 SHALL force weight to 9'h000 immediately, asynchronously.
REQ-026 weight SHALL hold 9'h000 while rst=0.
REQ-027 Writes SHALL be blocked while rst=0.
REQ-028 Memory rows SHALL retain their contents through reset.
REQ-029 First edge after rst deasserts SHALL produce a normal registered read.
REQ-030 rst asserted mid-sequence SHALL abort the read stream with no memory corruption.

Verification
REQ-031 With CLAUSEN=10, CLASSN=10, bram_addr_2=3, clauses=10: write row 3 with slot9 (MSB)=9'h005, slot0=9'h1FF. Then clause_no=1 -> weight=9'h005 next edge; clause_no=10 -> weight=9'h1FF next edge.
REQ-032 clauses=4 on the same row with slot3=9'h07A: clause_no=1 -> weight=9'h07A; clause_no=5 -> 9'h000; clause_no=0 -> 9'h000.
REQ-033 Write row 2 only on an instance with bram_addr_2=3 -> row-3 reads are unchanged; writes with bram_addr_a2=12 are ignored.
REQ-034 Same-edge write of row 3 slot0 9'h1FF->9'h010 while clause_no=10 -> weight=9'h1FF that edge, 9'h010 the following edge.
REQ-035 Assert rst=0 between edges while weight=9'h010 -> weight=9'h000 immediately. Release rst with clause_no=10 -> weight=9'h010 after one edge (memory retained).
REQ-036 Sweep clause_no 1..10 with clauses=10 on row [slot i = i+1] -> weight sequence 10,9,...,1, each one cycle after its clause_no.
